// File: rtl/dram_pkg.sv
// dram_pkg: shared types and constants for the data-RAM port arbiter.
package dram_pkg;
    localparam int AWIDTH_DEF = 3;
    localparam int DWIDTH_DEF = 32;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_tag_t;

    localparam req_id_t REQ_CORE = 1'b0;
    localparam req_id_t REQ_LOAD = 1'b1;
endpackage

// File: rtl/dram_rr_pick.sv
// dram_rr_pick: 2-way priority picker; prio_i names the requester that wins a tie.
module dram_rr_pick
    import dram_pkg::*;
(
    input  logic    [1:0] req_i,
    input  req_id_t       prio_i,
    output logic    [1:0] gnt_o
);
    assign gnt_o = (&req_i) ? ((prio_i == REQ_LOAD) ? 2'b10 : 2'b01) : req_i;
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: two-requester arbiter for a single-port sync-read RAM.
// DRAM_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module dram_port_arbiter
    import dram_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [AWIDTH-1:0] addr0_i,
    input  logic [AWIDTH-1:0] addr1_i,
    input  logic [DWIDTH-1:0] wdata0_i,
    input  logic [DWIDTH-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic [AWIDTH-1:0] ram_addr_o,
    output logic [DWIDTH-1:0] ram_din_o,
    output logic              ram_we_o,
    input  logic [DWIDTH-1:0] ram_dout_i
);
    logic [1:0]        pick_gnt, gnt;
    req_id_t           prio;
    logic [AWIDTH-1:0] addr_q, addr_d;
    rsp_tag_t          tag_q, tag_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;

`ifdef DRAM_ARB_RR_EN
    req_id_t prio_q, prio_d;

    // After a transfer the other requester gets the next tie.
    assign prio_d = (|gnt) ? (gnt[0] ? REQ_LOAD : REQ_CORE) : prio_q;
    assign prio   = prio_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) prio_q <= REQ_CORE;
        else            prio_q <= prio_d;
    end
`else
    assign prio = REQ_CORE;
`endif

    dram_rr_pick u_pick (
        .req_i  (req_i),
        .prio_i (prio),
        .gnt_o  (pick_gnt)
    );

    assign gnt = reset_n_i ? pick_gnt : 2'b00;

    always_comb begin
        addr_d    = gnt[0] ? addr0_i : gnt[1] ? addr1_i : addr_q;
        ram_din_o = gnt[0] ? wdata0_i : gnt[1] ? wdata1_i : '0;
        ram_we_o  = |(gnt & we_i);
        tag_d     = '{valid: |(gnt & ~we_i), id: (gnt[1] ? REQ_LOAD : REQ_CORE)};
        rvalid_d  = {tag_q.valid & (tag_q.id == REQ_LOAD), tag_q.valid & (tag_q.id == REQ_CORE)};
        rdata_d   = tag_q.valid ? ram_dout_i : rdata_q;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q   <= '0;
            tag_q    <= '0;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gnt_o      = gnt;
    assign ram_addr_o = addr_d;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed bench with a read-first sync RAM model.
module tb_dram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, gnt, rvalid;
    logic [2:0]  addr0, addr1, ram_addr;
    logic [31:0] wdata0, wdata1, rdata, ram_din, ram_dout;
    logic        ram_we;
    logic [31:0] mem [8];
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    dram_port_arbiter dut (
        .clock_i    (clk),
        .reset_n_i  (rst_n),
        .req_i      (req),
        .we_i       (we),
        .addr0_i    (addr0),
        .addr1_i    (addr1),
        .wdata0_i   (wdata0),
        .wdata1_i   (wdata1),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_we_o   (ram_we),
        .ram_dout_i (ram_dout)
    );

    task automatic write_word(input logic id, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        req = id ? 2'b10 : 2'b01;
        we  = req;
        if (id) begin addr1 = a; wdata1 = d; end
        else    begin addr0 = a; wdata0 = d; end
        @(negedge clk);
        req = 2'b00;
        we  = 2'b00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 2'b11; we = 2'b11;
        addr0 = 3'd1; addr1 = 3'd2; wdata0 = 32'h1; wdata1 = 32'h2;
        repeat (2) @(negedge clk);
        vecs++; if (gnt !== 2'b00) begin errs++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        vecs++; if (rvalid !== 2'b00) begin errs++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
        req = 2'b00; we = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        vecs++; if (rvalid !== 2'b00) begin errs++; $display("FAIL reset_rvalid_post: got %b expected 00", rvalid); end
    endtask

    task automatic test_contention;
        logic [1:0] exp;
        exp = 2'b01;
        req = 2'b11; we = 2'b00; addr0 = 3'd0; addr1 = 3'd1;
        for (int i = 0; i < 6; i++) begin
            #1;
            vecs++; if (gnt !== exp) begin errs++; $display("FAIL contention_gnt[%0d]: got %b expected %b", i, gnt, exp); end
            if (i >= 2) begin
                vecs++; if (rvalid !== exp) begin errs++; $display("FAIL contention_rvalid[%0d]: got %b expected %b", i, rvalid, exp); end
            end
            @(negedge clk);
`ifdef DRAM_ARB_RR_EN
            exp = ~exp;
`endif
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_read;
        @(negedge clk);
        req = 2'b01; we = 2'b00; addr0 = 3'd3;
        #1;
        vecs++; if (gnt !== 2'b01) begin errs++; $display("FAIL single_gnt: got %b expected 01", gnt); end
        vecs++; if (ram_addr !== 3'd3) begin errs++; $display("FAIL single_ram_addr: got %0d expected 3", ram_addr); end
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL single_ram_we: got %b expected 0", ram_we); end
        @(negedge clk);
        req = 2'b00;
        #1;
        vecs++; if (gnt !== 2'b00) begin errs++; $display("FAIL single_gnt_drop: got %b expected 00", gnt); end
        vecs++; if (rvalid !== 2'b00) begin errs++; $display("FAIL single_rvalid_early: got %b expected 00", rvalid); end
        @(negedge clk);
        vecs++; if (rvalid !== 2'b01) begin errs++; $display("FAIL single_rvalid: got %b expected 01", rvalid); end
        vecs++; if (rdata !== 32'h0000_00A5) begin errs++; $display("FAIL single_rdata: got %h expected 000000a5", rdata); end
        @(negedge clk);
        vecs++; if (rvalid !== 2'b00) begin errs++; $display("FAIL single_rvalid_pulse: got %b expected 00", rvalid); end
        vecs++; if (rdata !== 32'h0000_00A5) begin errs++; $display("FAIL single_rdata_hold: got %h expected 000000a5", rdata); end
    endtask

    task automatic test_write_then_read;
        @(negedge clk);
        req = 2'b10; we = 2'b10; addr1 = 3'd5; wdata1 = 32'hDEAD_BEEF;
        #1;
        vecs++; if (gnt !== 2'b10) begin errs++; $display("FAIL wr_gnt: got %b expected 10", gnt); end
        vecs++; if (ram_we !== 1'b1) begin errs++; $display("FAIL wr_ram_we: got %b expected 1", ram_we); end
        vecs++; if (ram_din !== 32'hDEAD_BEEF) begin errs++; $display("FAIL wr_ram_din: got %h expected deadbeef", ram_din); end
        @(negedge clk);
        we = 2'b00;
        #1;
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL rd_ram_we: got %b expected 0", ram_we); end
        @(negedge clk);
        req = 2'b00;
        vecs++; if (rvalid !== 2'b00) begin errs++; $display("FAIL wr_no_rvalid: got %b expected 00", rvalid); end
        @(negedge clk);
        vecs++; if (rvalid !== 2'b10) begin errs++; $display("FAIL wtr_rvalid: got %b expected 10", rvalid); end
        vecs++; if (rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL wtr_rdata: got %h expected deadbeef", rdata); end
    endtask

    task automatic test_hazard;
        @(negedge clk);
        req = 2'b01; we = 2'b00; addr0 = 3'd2;
        @(negedge clk);
        req = 2'b10; we = 2'b10; addr1 = 3'd2; wdata1 = 32'h22;
        #1;
        vecs++; if (gnt !== 2'b10) begin errs++; $display("FAIL hz_gnt: got %b expected 10", gnt); end
        vecs++; if (ram_din !== 32'h22) begin errs++; $display("FAIL hz_ram_din: got %h expected 00000022", ram_din); end
        @(negedge clk);
        req = 2'b00; we = 2'b00;
        #1;
        vecs++; if (rvalid !== 2'b01) begin errs++; $display("FAIL hz_rvalid: got %b expected 01", rvalid); end
        vecs++; if (rdata !== 32'h11) begin errs++; $display("FAIL hz_rdata_old: got %h expected 00000011", rdata); end
        vecs++; if (ram_addr !== 3'd2) begin errs++; $display("FAIL idle_ram_addr: got %0d expected 2", ram_addr); end
        vecs++; if (ram_din !== 32'h0) begin errs++; $display("FAIL idle_ram_din: got %h expected 00000000", ram_din); end
        @(negedge clk);
        req = 2'b01; addr0 = 3'd2;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        vecs++; if (rvalid !== 2'b01) begin errs++; $display("FAIL hz_rvalid2: got %b expected 01", rvalid); end
        vecs++; if (rdata !== 32'h22) begin errs++; $display("FAIL hz_rdata_new: got %h expected 00000022", rdata); end
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        req = 2'b01; we = 2'b00; addr0 = 3'd3;
        @(negedge clk);
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL mid_rdata_rst: got %h expected 00000000", rdata); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            vecs++; if (rvalid !== 2'b00) begin errs++; $display("FAIL mid_rvalid[%0d]: got %b expected 00", i, rvalid); end
        end
        vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL mid_rdata: got %h expected 00000000", rdata); end
    endtask

    initial begin
        test_reset;
        test_contention;
        write_word(1'b0, 3'd3, 32'h0000_00A5);
        write_word(1'b1, 3'd2, 32'h0000_0011);
        test_single_read;
        test_write_then_read;
        test_hazard;
        test_reset_mid_read;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Two-requester arbiter for the single-port, synchronous-read data RAM (one shared address, separate din/dout, write enable, one-cycle read latency). It sits between the RAM and its two masters, requester 0 (core load/store) and requester 1 (loader/DMA). It grants at most one access per cycle, drives the RAM port from the granted requester, and returns read data, tagged back to the issuing requester, through a registered response stage.

## Interface
- AWIDTH, 3, RAM address width; depth = 2^AWIDTH
- DWIDTH, 32, RAM data width
- clock  in  1  rising-edge clock shared with the RAM
- reset_n  in  1  asynchronous, active-low reset
- req  in  2  access request per requester; held until granted
- we  in  2  per-requester write (1) / read (0) qualifier
- addr0, addr1  in  AWIDTH  per-requester address
- wdata0, wdata1  in  DWIDTH  per-requester write data
- gnt  out  2  one-hot/zero grant; transfer = req[i] & gnt[i] at rising edge
- rvalid  out  2  one-cycle read-data strobe to the issuing requester
- rdata  out  DWIDTH  registered read data, shared by both requesters
- ram_addr  out  AWIDTH  to RAM addr
- ram_din  out  DWIDTH  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  DWIDTH  from RAM dout

## Operation
- Grant logic is combinational from req and the priority state. gnt is never more than one-hot, and gnt[i] requires req[i].
- RAM mux: ram_addr, ram_din and ram_we follow the granted requester. ram_we = we[i] & gnt[i]. With no grant, ram_addr holds the last granted address, ram_din = 0 and ram_we = 0.
- Read pipeline, for a granted read at edge N:
  - The RAM latches the address at edge N.
  - ram_dout is valid during cycle N+1.
  - The arbiter captures ram_dout into rdata at edge N+1 and pulses rvalid[i] for one cycle after N+1.
  - Tag register: 1-bit valid plus 1-bit requester ID, loaded at every edge.
- Writes produce no rvalid.
- Back-to-back reads, including alternating requesters, sustain one per cycle. Tags never collide because the read pipeline is one deep.
- Read at edge N followed by a write to the same address at edge N+1: the read returns the pre-write data.
- Write at edge N followed by a read of the same address at edge N+1: the read returns the new data.
- rdata holds its value when rvalid = 0.
- Requesters may drop req only after being granted. A req that drops before grant is treated as never made.

## Timing
- Reset (reset_n low, asynchronous):
  - rvalid = 0, rdata = 0, tag cleared, priority pointer = requester 0.
  - gnt = 0 and ram_we = 0, forced while reset_n is low.
- Reset deasserted mid-read: the response is lost and rvalid stays 0. Requesters re-issue.
- Grant-to-rvalid latency: 2 rising edges. The RAM itself adds 1.
- Throughput: 1 access per cycle total. With both requesting continuously, each requester gets at least 1 access per 2 cycles (RR build).

## Configuration
- DRAM_ARB_RR_EN defined: round-robin.
  - A 1-bit last-grant pointer updates on every transfer.
  - When both request, the requester not granted last wins.
- DRAM_ARB_RR_EN undefined: fixed priority, requester 0 always wins.
  - No pointer register exists.
  - Requester 1 can starve; this is accepted.

## Structure
- Shared package dram_pkg holds:
  - AWIDTH/DWIDTH defaults
  - the requester-ID type (1 bit)
  - the response-tag struct (valid, id)
  - named constants REQ_CORE = 0, REQ_LOAD = 1
- Natural sub-module: dram_rr_pick. It is the 2-way priority picker (req, pointer -> gnt) and is bypassed to fixed priority when the macro is absent.
- The RAM itself is instantiated outside the arbiter.

## Test plan
- Reset: with reset_n low and req = 2'b11, gnt = 0, ram_we = 0 and rvalid = 0. After release, rdata = 0.
- Single read: requester 0 reads addr 3, preloaded 0x0000_00A5. gnt[0] is high one cycle, rvalid[0] pulses 2 edges later, and rdata = 0x0000_00A5. rvalid[1] stays 0.
- Write then read: requester 1 writes 0xDEAD_BEEF to addr 5, then reads addr 5 the next cycle. rvalid[1] pulses with rdata = 0xDEAD_BEEF.
- Read/write hazard:
  - Setup: addr 2 preloaded 0x11; requester 0 reads addr 2; requester 1 writes 0x22 to addr 2 the next cycle.
  - Expected: requester 0 gets rdata = 0x11, and a later read of addr 2 returns 0x22.
- Contention with req = 2'b11 held for 6 cycles:
  - RR build: gnt alternates 01, 10, 01, ... starting with 01 after reset.
  - Fixed build: gnt = 01 every cycle.
- Reset mid-read: assert reset_n low the cycle after a granted read. No rvalid is ever produced, and rdata = 0.
